imem_responder: RTL

Instruction-memory responder that answers the CPU's instruction fetch requests. The CPU raises `en_ram_in` with a fetch address on `addr`. This block returns the stored 16-bit word on `ins` and asserts `en_ram_out` after a configurable wait-state latency. It also provides a write port so the program image can be loaded before or between runs. It sits between the CPU core and the top-level program-load logic.

---
 rtl/imem_pkg.sv | 9 +
 rtl/imem_array.sv | 22 ++
 rtl/imem_responder.sv | 84 ++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM encoding, NOP word and default sizing for the instruction-memory responder
package imem_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [15:0] NOP = 16'h0000;
  localparam int DEF_LAT = 2;
  localparam int DEF_ADDR_W = 8;
endpackage

// File: rtl/imem_array.sv
// imem_array: 1-write/1-read synchronous RAM with registered, read-before-write read port
module imem_array
  import imem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);
  logic [15:0] mem [2**ADDR_W];
  logic [15:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/imem_responder.sv
// imem_responder: four-phase instruction fetch responder with wait states and a program-load port
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LAT    = DEF_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_ram_in,
  input  logic [15:0] addr,
  output logic [15:0] ins,
  output logic        en_ram_out,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        busy
);
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic en_q, en_d, busy_q, busy_d, zero_q, zero_d, rd_en, ld_ok;
  logic [15:0] rd_data;
  assign ld_ok = ld_en && (ld_addr[15:ADDR_W] == '0);
  imem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (ld_ok),
    .waddr (ld_addr[ADDR_W-1:0]),
    .wdata (ld_data),
    .re    (rd_en),
    .raddr (addr_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    en_d = en_q;
    zero_d = zero_q;
    rd_en = 1'b0;
    case (state_q)
      S_IDLE: if (en_ram_in) begin
        state_d = S_WAIT;
        addr_d = addr;
        cnt_d = CNT_INIT;
      end
      S_WAIT: if (!en_ram_in) state_d = S_IDLE;
      else if (cnt_q == 4'd0) begin
        rd_en = 1'b1;
        zero_d = addr_q[15:ADDR_W] != '0;
        en_d = 1'b1;
        state_d = S_RESP;
      end else cnt_d = cnt_q - 4'd1;
      S_RESP: if (!en_ram_in) begin
        en_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= 4'd0;
      addr_q <= 16'h0000;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      en_q <= en_d;
      busy_q <= busy_d;
      zero_q <= zero_d;
    end
  end
  // RAM output has no reset; zero_q forces the NOP word after reset and for out-of-range fetches
  assign ins = zero_q ? NOP : rd_data;
  assign en_ram_out = en_q;
  assign busy = busy_q;
endmodule
